bp_me_io_load_arbiter: RTL
==========================

// Module: bp_me_io_load_arbiter
// PURPOSE
//  Shares the single host-side I/O load link (bp_cce_io_msg_s command/response pair) between
//  num_req_p on-testbench requesters, e.g. NBF loader, CCE cfg loader and a debug poker.
//  Arbitrates commands per message and records the grant index of every accepted command in an
//  in-order tag FIFO. Routes each returning response to the requester that issued it.
//  Sits between the requesters and bp_me_cce_to_io_link_bidir.
// PARAMETERS
//  bp_params_p        e_bp_default_cfg   processor config; derives io_msg_width_lp = width of bp_cce_io_msg_s
//  num_req_p          2                  number of requesters (>=1)
//  max_outstanding_p  4                  tag FIFO depth = max commands in flight without a response (>=1)
// PORTS
//  clk_i         in   1                          clock
//  reset_i       in   1                          synchronous, active-high reset
//  req_cmd_i     in   num_req_p*io_msg_width_lp  per-requester command message
//  req_cmd_v_i   in   num_req_p                  per-requester command valid
//  req_cmd_ready_o out num_req_p                 per-requester command ready (ready&valid handshake)
//  req_resp_o    out  io_msg_width_lp            response message, broadcast to all requesters
//  req_resp_v_o  out  num_req_p                  one-hot response valid for the owning requester
//  req_resp_ready_i in num_req_p                 per-requester response ready
//  io_cmd_o      out  io_msg_width_lp            arbitrated command to link
//  io_cmd_v_o    out  1                          command valid
//  io_cmd_ready_i in  1                          link command ready (ready&valid handshake)
//  io_resp_i     in   io_msg_width_lp            response from link
//  io_resp_v_i   in   1                          response valid
//  io_resp_yumi_o out 1                          response consumed (valid-then-yumi handshake)
//  idle_o        out  1                          high when no command is outstanding (tag FIFO empty)
// BEHAVIOUR
//  Reset: RR pointer=0, tag FIFO empty, outstanding count=0. While reset_i is high, all v/ready/yumi
//   outputs are 0 and idle_o=1. Reset during in-flight traffic drops all tags; later responses are
//   unmatched (see below).
//  Command path is combinational, with 0-cycle latency:
//   - eligible = req_cmd_v_i & {num_req_p{~fifo_full}}
//   - grant = first eligible index at or after the RR pointer, with wrap-around
//   - io_cmd_o = req_cmd_i[grant]; io_cmd_v_o = |eligible
//   - req_cmd_ready_o[grant] = io_cmd_ready_i; every other bit = 0
//   - io_cmd_v_o never depends on io_cmd_ready_i
//  Accept = io_cmd_v_o & io_cmd_ready_i. On accept:
//   - push grant into the tag FIFO
//   - RR pointer <= (grant+1) mod num_req_p
//   Without an accept the pointer holds, so a stalled grant stays stable until accepted.
//  Full: when the FIFO holds max_outstanding_p tags, all commands are blocked. This holds even if a
//   response dequeues in the same cycle; there is no bypass, giving a registered-only full path.
//  Response path is combinational, with 0-cycle latency:
//   - head = FIFO head tag
//   - req_resp_o = io_resp_i
//   - req_resp_v_o = io_resp_v_i & ~fifo_empty, one-hot at head
//   - io_resp_yumi_o = io_resp_v_i & ~fifo_empty & req_resp_ready_i[head]
//   - pop the FIFO on io_resp_yumi_o
//  Simultaneous push and pop in one cycle: both take effect; count is unchanged; FIFO order is kept.
//  Unmatched response (io_resp_v_i while FIFO empty): not consumed, yumi=0, stalls. A nonsynth
//   assertion fires an error.
//  idle_o = fifo_empty. The count never exceeds max_outstanding_p; it wraps modulo FIFO depth only
//   via its pointers.
// CONFIGURATION
//  BP_IO_LOAD_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest eligible index always wins and
//   the RR pointer is removed. Undefined (default): round-robin as above.
// TESTING
//  1. Reset, then req 0 alone sends 3 cmds with ready=1 -> 3 accepts in 3 cycles; 3 responses route
//     to req_resp_v_o=2'b01; idle_o returns to 1.
//  2. Both reqs valid continuously, ready=1 -> grants alternate 0,1,0,1. With FIXED_PRIO_EN ->
//     always 0.
//  3. max_outstanding_p=4, no responses -> exactly 4 accepts, then req_cmd_ready_o=0. One response
//     -> one more accept the next cycle, not the same cycle.
//  4. io_cmd_ready_i=0 for 5 cycles with req 1 granted -> io_cmd_o is stable and the pointer is
//     unchanged; accept occurs on the cycle ready rises.
//  5. Interleaved tags 0,1,1,0 with req_resp_ready_i[1]=0 for 3 cycles -> the 2nd response is held
//     (yumi=0), then delivered in order; no reordering.
//  6. Response valid with FIFO empty -> yumi stays 0 and the assertion fires. Reset mid-traffic ->
//     idle_o=1 the next cycle.

Source files
------------

// File: rtl/bp_me_io_load_arbiter.sv
// Arbitrates N requesters onto one host I/O load link and routes responses back in issue order.
// Define BP_IO_LOAD_ARB_FIXED_PRIO_EN to select fixed priority (lowest index wins) instead of round-robin.

package bp_me_io_load_arbiter_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg    = 2'd0,
        e_bp_unicore_cfg    = 2'd1,
        e_bp_multicore_cfg  = 2'd2
    } bp_params_e;

    // Width of bp_cce_io_msg_s: 64-bit header (type/addr/size/payload) plus 64-bit data.
    function automatic int unsigned io_msg_width(input bp_params_e cfg);
        case (cfg)
            e_bp_unicore_cfg:   return 128;
            e_bp_multicore_cfg: return 128;
            default:            return 128;
        endcase
    endfunction

endpackage

module bp_me_io_load_arbiter
    import bp_me_io_load_arbiter_pkg::*;
#(
    parameter bp_params_e  bp_params_p          = e_bp_default_cfg,
    parameter int unsigned num_req_p            = 2,
    parameter int unsigned max_outstanding_p    = 4,
    parameter bit          unmatched_resp_err_p = 1'b1,
    localparam int unsigned io_msg_width_lp     = io_msg_width(bp_params_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,

    input  logic [num_req_p*io_msg_width_lp-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]                 req_cmd_v_i,
    output logic [num_req_p-1:0]                 req_cmd_ready_o,

    output logic [io_msg_width_lp-1:0]           req_resp_o,
    output logic [num_req_p-1:0]                 req_resp_v_o,
    input  logic [num_req_p-1:0]                 req_resp_ready_i,

    output logic [io_msg_width_lp-1:0]           io_cmd_o,
    output logic                                 io_cmd_v_o,
    input  logic                                 io_cmd_ready_i,

    input  logic [io_msg_width_lp-1:0]           io_resp_i,
    input  logic                                 io_resp_v_i,
    output logic                                 io_resp_yumi_o,

    output logic                                 idle_o
);

    localparam int unsigned lg_req_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned lg_depth_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int unsigned cnt_w_lp    = $clog2(max_outstanding_p + 1);

    logic [io_msg_width_lp-1:0] cmd_arr [num_req_p];

    logic [lg_req_lp-1:0]   tag_mem_q [max_outstanding_p];
    logic [lg_req_lp-1:0]   tag_mem_d [max_outstanding_p];
    logic [lg_depth_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [lg_depth_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]    count_q, count_d;

    logic                   fifo_full, fifo_empty;
    logic [num_req_p-1:0]   eligible;
    logic [lg_req_lp-1:0]   grant;
    logic [lg_req_lp-1:0]   cand;
    logic                   found;
    logic                   accept;
    logic [lg_req_lp-1:0]   head;
    logic                   resp_v;
    logic                   pop;

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign cmd_arr[g] = req_cmd_i[g*io_msg_width_lp +: io_msg_width_lp];
    end

    assign fifo_full  = (count_q == cnt_w_lp'(max_outstanding_p));
    assign fifo_empty = (count_q == '0);

    // Full blocks on the registered count only, so a same-cycle pop never frees a slot.
    assign eligible = req_cmd_v_i & {num_req_p{~fifo_full & ~reset_i}};

`ifdef BP_IO_LOAD_ARB_FIXED_PRIO_EN

    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            cand = lg_req_lp'(i);
            if (!found && eligible[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

`else

    logic [lg_req_lp-1:0] rr_ptr_q, rr_ptr_d;

    // Search starts at the pointer and wraps, so the last winner has lowest priority next.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            cand = lg_req_lp'((32'(rr_ptr_q) + i) % num_req_p);
            if (!found && eligible[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant == lg_req_lp'(num_req_p - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`endif

    assign io_cmd_v_o      = |eligible;
    assign io_cmd_o        = cmd_arr[grant];
    assign accept          = io_cmd_v_o & io_cmd_ready_i;
    assign req_cmd_ready_o = num_req_p'(io_cmd_v_o & io_cmd_ready_i) << grant;

    assign head           = tag_mem_q[rd_ptr_q];
    assign resp_v         = io_resp_v_i & ~fifo_empty & ~reset_i;
    assign req_resp_o     = io_resp_i;
    assign req_resp_v_o   = num_req_p'(resp_v) << head;
    assign io_resp_yumi_o = resp_v & req_resp_ready_i[head];
    assign pop            = io_resp_yumi_o;

    assign idle_o = fifo_empty | reset_i;

    function automatic logic [lg_depth_lp-1:0] ptr_inc(input logic [lg_depth_lp-1:0] p);
        return (p == lg_depth_lp'(max_outstanding_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + cnt_w_lp'(accept) - cnt_w_lp'(pop);
        if (accept) begin
            tag_mem_d[wr_ptr_q] = grant;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tag_mem_q <= tag_mem_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (unmatched_resp_err_p) begin
                assert (!(io_resp_v_i && fifo_empty))
                    else $error("bp_me_io_load_arbiter: response with no outstanding command");
            end
            assert (count_q <= cnt_w_lp'(max_outstanding_p))
                else $error("bp_me_io_load_arbiter: outstanding count overflow");
        end
    end
`endif

endmodule
